// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares the single memory port between instruction fetch (IFU) and
//   load/store (LSU). Each transaction runs to completion or times out.
//   The response is then routed back to the requester that owns it.
//   Only one memory transaction is ever outstanding.
//
// Ports
//   clk, rst                      clock (rising edge), async active-high reset
//   ifu_req/ifu_addr              IFU read request, held until ifu_gnt
//   ifu_gnt                       IFU accepted this cycle (combinational)
//   ifu_rvalid/ifu_rdata/ifu_err  IFU response pulse, data, timeout flag
//   lsu_req/wen/addr/wdata/wmask  LSU request, held until lsu_gnt
//   lsu_gnt                       LSU accepted this cycle (combinational)
//   lsu_rvalid/lsu_rdata/lsu_err  LSU response pulse, data (0 on writes), timeout
//   mem_valid/wen/addr/wdata/wmask  memory request, fields latched at grant
//   mem_ready                     memory accepts the request
//   mem_rvalid/mem_rdata          memory response (read data or write ack)
module mem_port_arbiter #(
    parameter int unsigned ADDR_W   = 32,
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned MASK_W   = 8,
    parameter int unsigned MAX_WAIT = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifu_req,
    input  logic [ADDR_W-1:0] ifu_addr,
    output logic              ifu_gnt,
    output logic              ifu_rvalid,
    output logic [DATA_W-1:0] ifu_rdata,
    output logic              ifu_err,
    input  logic              lsu_req,
    input  logic              lsu_wen,
    input  logic [ADDR_W-1:0] lsu_addr,
    input  logic [DATA_W-1:0] lsu_wdata,
    input  logic [MASK_W-1:0] lsu_wmask,
    output logic              lsu_gnt,
    output logic              lsu_rvalid,
    output logic [DATA_W-1:0] lsu_rdata,
    output logic              lsu_err,
    output logic              mem_valid,
    output logic              mem_wen,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [MASK_W-1:0] mem_wmask,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;

    localparam logic OWN_IFU = 1'b0;
    localparam logic OWN_LSU = 1'b1;

    localparam int unsigned           CNT_W    = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0]      CNT_LAST = CNT_W'(MAX_WAIT - 1);

    logic [1:0]        state;
    logic [CNT_W-1:0]  wait_cnt;
    logic              owner;
    logic              last;
    logic              wen_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [MASK_W-1:0] wmask_q;

    logic idle;
    logic busy;
    logic done;
    logic timeout;

    always_comb begin
        idle = (state == ST_IDLE);
        busy = (state == ST_ISSUE) || (state == ST_WAIT);
        // Round robin only matters when both requesters are pending.
        ifu_gnt = idle && ifu_req && (!lsu_req || (last == OWN_LSU));
        lsu_gnt = idle && lsu_req && (!ifu_req || (last == OWN_IFU));
        done    = ((state == ST_ISSUE) && mem_ready && mem_rvalid) ||
                  ((state == ST_WAIT) && mem_rvalid);
        // Completion in the final counted cycle takes priority over timeout.
        timeout = busy && !done && (wait_cnt == CNT_LAST);
    end

    always_comb begin
        mem_valid = (state == ST_ISSUE);
        mem_wen   = mem_valid && wen_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_wmask = wmask_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            owner      <= OWN_IFU;
            last       <= OWN_LSU;
            wen_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            ifu_rvalid <= 1'b0;
            ifu_rdata  <= '0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_rdata  <= '0;
            lsu_err    <= 1'b0;
        end else begin
            ifu_rvalid <= 1'b0;
            ifu_err    <= 1'b0;
            lsu_rvalid <= 1'b0;
            lsu_err    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (lsu_gnt) begin
                        state    <= ST_ISSUE;
                        wait_cnt <= '0;
                        owner    <= OWN_LSU;
                        last     <= OWN_LSU;
                        wen_q    <= lsu_wen;
                        addr_q   <= lsu_addr;
                        wdata_q  <= lsu_wdata;
                        wmask_q  <= lsu_wen ? lsu_wmask : '0;
                    end else if (ifu_gnt) begin
                        state    <= ST_ISSUE;
                        wait_cnt <= '0;
                        owner    <= OWN_IFU;
                        last     <= OWN_IFU;
                        wen_q    <= 1'b0;
                        addr_q   <= ifu_addr;
                        wdata_q  <= '0;
                        wmask_q  <= '0;
                    end
                end
                ST_ISSUE, ST_WAIT: begin
                    if (done || timeout) begin
                        state <= ST_IDLE;
                        if (owner == OWN_LSU) begin
                            lsu_rvalid <= 1'b1;
                            lsu_err    <= timeout;
                            lsu_rdata  <= (done && !wen_q) ? mem_rdata : '0;
                        end else begin
                            ifu_rvalid <= 1'b1;
                            ifu_err    <= timeout;
                            ifu_rdata  <= done ? mem_rdata : '0;
                        end
                    end else begin
                        if ((state == ST_ISSUE) && mem_ready) begin
                            state <= ST_WAIT;
                        end
                        if (wait_cnt != CNT_LAST) begin
                            wait_cnt <= wait_cnt + 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

    localparam int unsigned ADDR_W   = 32;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned MASK_W   = 8;
    localparam int unsigned MAX_WAIT = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              ifu_req = 1'b0;
    logic [ADDR_W-1:0] ifu_addr = '0;
    logic              ifu_gnt, ifu_rvalid, ifu_err;
    logic [DATA_W-1:0] ifu_rdata;
    logic              lsu_req = 1'b0, lsu_wen = 1'b0;
    logic [ADDR_W-1:0] lsu_addr = '0;
    logic [DATA_W-1:0] lsu_wdata = '0;
    logic [MASK_W-1:0] lsu_wmask = '0;
    logic              lsu_gnt, lsu_rvalid, lsu_err;
    logic [DATA_W-1:0] lsu_rdata;
    logic              mem_valid, mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [MASK_W-1:0] mem_wmask;
    logic              mem_ready = 1'b0, mem_rvalid = 1'b0;
    logic [DATA_W-1:0] mem_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MASK_W(MASK_W), .MAX_WAIT(MAX_WAIT)
    ) dut (
        .clk(clk), .rst(rst),
        .ifu_req(ifu_req), .ifu_addr(ifu_addr), .ifu_gnt(ifu_gnt),
        .ifu_rvalid(ifu_rvalid), .ifu_rdata(ifu_rdata), .ifu_err(ifu_err),
        .lsu_req(lsu_req), .lsu_wen(lsu_wen), .lsu_addr(lsu_addr),
        .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask), .lsu_gnt(lsu_gnt),
        .lsu_rvalid(lsu_rvalid), .lsu_rdata(lsu_rdata), .lsu_err(lsu_err),
        .mem_valid(mem_valid), .mem_wen(mem_wen), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_ready(mem_ready),
        .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: a single outstanding transaction with an
    // owner, an age in cycles and an "accepted by memory" flag.
    bit              m_busy, m_acc, m_owner_lsu, m_last_lsu, m_wen;
    int unsigned     m_age;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wdata;
    logic [MASK_W-1:0] m_wmask;
    bit              m_rv_i, m_rv_l, m_err;
    logic [DATA_W-1:0] m_rdata;

    int unsigned ifu_pulses = 0, lsu_pulses = 0;
    bit          log_grants = 0;
    bit          grant_q[$];

    always @(negedge clk) begin
        bit eg_i, eg_l, fin, tmo;
        ifu_pulses += int'(ifu_rvalid);
        lsu_pulses += int'(lsu_rvalid);
        if (rst) begin
            m_busy = 0; m_acc = 0; m_age = 0; m_owner_lsu = 0; m_last_lsu = 1;
            m_rv_i = 0; m_rv_l = 0; m_err = 0;
            if (!ifu_req && !lsu_req) begin
                cmp("rst_outputs",
                    {ifu_gnt, ifu_rvalid, ifu_err, lsu_gnt, lsu_rvalid, lsu_err, mem_valid, mem_wen},
                    64'd0);
                cmp("rst_buses", {mem_addr, mem_wdata}, 64'd0);
            end
        end else begin
            eg_i = !m_busy && ifu_req && (!lsu_req || m_last_lsu);
            eg_l = !m_busy && lsu_req && (!ifu_req || !m_last_lsu);
            cmp("ifu_gnt", ifu_gnt, eg_i);
            cmp("lsu_gnt", lsu_gnt, eg_l);
            cmp("mem_valid", mem_valid, m_busy && !m_acc);
            cmp("mem_wen", mem_wen, m_busy && !m_acc && m_wen);
            if (m_busy && !m_acc) begin
                cmp("mem_addr", mem_addr, m_addr);
                cmp("mem_wdata", mem_wdata, m_wen ? m_wdata : '0);
                cmp("mem_wmask", mem_wmask, m_wen ? m_wmask : '0);
            end
            cmp("ifu_rvalid", ifu_rvalid, m_rv_i);
            cmp("lsu_rvalid", lsu_rvalid, m_rv_l);
            if (m_rv_i) begin
                cmp("ifu_rdata", ifu_rdata, m_rdata);
                cmp("ifu_err", ifu_err, m_err);
            end
            if (m_rv_l) begin
                cmp("lsu_rdata", lsu_rdata, m_rdata);
                cmp("lsu_err", lsu_err, m_err);
            end
            if (log_grants && (eg_i || eg_l)) grant_q.push_back(eg_l);

            m_rv_i = 0; m_rv_l = 0;
            if (m_busy) begin
                fin = m_acc ? mem_rvalid : (mem_ready && mem_rvalid);
                tmo = !fin && (m_age == MAX_WAIT - 1);
                if (fin || tmo) begin
                    m_busy = 0;
                    m_rv_l = m_owner_lsu;
                    m_rv_i = !m_owner_lsu;
                    m_err  = tmo;
                    m_rdata = (fin && !m_wen) ? mem_rdata : '0;
                end else begin
                    m_age++;
                    if (!m_acc && mem_ready) m_acc = 1;
                end
            end else if (eg_i || eg_l) begin
                m_busy = 1; m_acc = 0; m_age = 0;
                m_owner_lsu = eg_l; m_last_lsu = eg_l;
                m_wen   = eg_l && lsu_wen;
                m_addr  = eg_l ? lsu_addr : ifu_addr;
                m_wdata = lsu_wdata;
                m_wmask = lsu_wmask;
            end
        end
    end

    initial begin
        int unsigned lat;
        bit seen, alt_ok;
        logic        err_seen;
        logic [DATA_W-1:0] rd_seen;

        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        cmp("reset_mem_valid", mem_valid, 1'b0);
        cmp("reset_rvalids", {ifu_rvalid, lsu_rvalid}, 2'b00);
        step();
        rst = 1'b0;
        step();

        // IFU only, zero-wait memory
        ifu_req = 1; ifu_addr = 32'h8000_0000;
        @(negedge clk);
        cmp("t2_gnt_c0", ifu_gnt, 1'b1);
        step();
        ifu_req = 0; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h0000_0413;
        @(negedge clk);
        cmp("t2_mem_valid_c1", mem_valid, 1'b1);
        cmp("t2_mem_addr_c1", mem_addr, 32'h8000_0000);
        step();
        mem_ready = 0; mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        cmp("t2_rvalid_c2", ifu_rvalid, 1'b1);
        cmp("t2_rdata_c2", ifu_rdata, 32'h0000_0413);
        step();

        // Both requesting every cycle from reset
        rst = 1; step(); rst = 0;
        grant_q.delete();
        log_grants = 1;
        ifu_req = 1; lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h8000_2000;
        ifu_addr = 32'h8000_0100; mem_ready = 1; mem_rvalid = 1; mem_rdata = 32'h1234_5678;
        repeat (40) step();
        ifu_req = 0; lsu_req = 0;
        @(negedge clk);
        log_grants = 0;
        step();
        mem_ready = 0; mem_rvalid = 0;
        step();
        cmp("t3_grant_count", grant_q.size(), 20);
        alt_ok = 1;
        foreach (grant_q[i]) if (grant_q[i] != bit'(i % 2)) alt_ok = 0;
        cmp("t3_alternating_from_ifu", alt_ok, 1'b1);

        // LSU write with delayed ready and ack
        lsu_pulses = 0;
        lsu_req = 1; lsu_wen = 1; lsu_addr = 32'h8000_1000;
        lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 8'h0F;
        @(negedge clk);
        cmp("t4_gnt_c0", lsu_gnt, 1'b1);
        step();
        lsu_req = 0; lsu_wen = 0; lsu_wdata = '0; lsu_wmask = '0;
        @(negedge clk);
        cmp("t4_wmask_c1", mem_wmask, 8'h0F);
        cmp("t4_wdata_c1", mem_wdata, 32'hDEAD_BEEF);
        step(); step(); step();
        mem_ready = 1;
        step();
        mem_ready = 0;
        step();
        mem_rvalid = 1;
        step();
        mem_rvalid = 0;
        @(negedge clk);
        cmp("t4_rvalid_c7", lsu_rvalid, 1'b1);
        cmp("t4_rdata_zero", lsu_rdata, 32'h0);
        repeat (3) step();
        cmp("t4_single_pulse", lsu_pulses, 1);

        // IFU timeout, then stray responses in IDLE
        ifu_pulses = 0;
        ifu_req = 1; ifu_addr = 32'h8000_0040;
        @(negedge clk);
        cmp("t5_gnt_c0", ifu_gnt, 1'b1);
        step();
        ifu_req = 0;
        seen = 0; lat = 0; err_seen = 0; rd_seen = '1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ifu_rvalid && !seen) begin
                seen = 1; lat = k; err_seen = ifu_err; rd_seen = ifu_rdata;
            end
            step();
            if (seen) break;
        end
        cmp("t5_response_seen", seen, 1'b1);
        cmp("t5_latency_from_issue", lat, 16);
        cmp("t5_err", err_seen, 1'b1);
        cmp("t5_rdata_zero", rd_seen, 32'h0);
        mem_rvalid = 1; mem_rdata = 32'hBAD0_BAD0;
        repeat (3) step();
        mem_rvalid = 0;
        repeat (2) step();
        cmp("t5_pulses", ifu_pulses, 1);

        // LSU read completing in the last counted cycle
        lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h8000_3000;
        step();
        lsu_req = 0; mem_ready = 1;
        step();
        mem_ready = 0;
        repeat (14) step();
        mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
        step();
        mem_rvalid = 0; mem_rdata = '0;
        @(negedge clk);
        cmp("t6_rvalid", lsu_rvalid, 1'b1);
        cmp("t6_err", lsu_err, 1'b0);
        cmp("t6_rdata", lsu_rdata, 32'hCAFE_F00D);
        step();

        // Reset while waiting for the memory response
        lsu_pulses = 0;
        lsu_req = 1; lsu_wen = 0; lsu_addr = 32'h8000_4000;
        step();
        lsu_req = 0; mem_ready = 1;
        step();
        mem_ready = 0;
        step();
        rst = 1;
        @(negedge clk);
        cmp("t7_mem_valid", mem_valid, 1'b0);
        cmp("t7_rvalid", lsu_rvalid, 1'b0);
        step();
        rst = 0; mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
        repeat (2) step();
        mem_rvalid = 0;
        repeat (2) step();
        cmp("t7_no_pulse", lsu_pulses, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
